// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    localparam int PS2_DATA_BITS = 8;

    // Odd parity: the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/debounce.sv
// Debouncer: sig_out follows sig_in only after sig_in has differed from it for CYCLES clk.
// Shorter excursions are ignored. Output resets to RESET_VAL.
module debounce #(
    parameter int   CYCLES    = 16,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_out
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    // NOTE: every flop here is sequential state, so only non-blocking assignments are used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            sig_out <= RESET_VAL;
        end else if (sig_in == sig_out) begin
            cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
            cnt     <= '0;
            sig_out <= sig_in;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: sync + debounce, 11-bit frame FSM, timeout, valid/ready hold.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking at the stop bit.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       dclk;
    logic       ddata;
    logic       dclk_q;
    logic       fall;

    ps2_rx_state_t state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    sreg_q;
    logic          timeout;
    logic          good_frame;
    logic          frame_err_d;
    logic          parity_ok;

    // The bus idles high, so synchronisers come out of reset at 1 to avoid a phantom fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            dclk_q    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            dclk_q    <= dclk;
        end
    end

    debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_clk_db (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (clk_sync[1]),
        .sig_out (dclk)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_data_db (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (data_sync[1]),
        .sig_out (ddata)
    );

    assign fall = dclk_q & ~dclk;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (fall && state_q == PARITY) begin
            parity_q <= ddata;
        end
    end

    assign parity_ok = odd_parity_ok(sreg_q, parity_q);
`else
    assign parity_ok = 1'b1;
`endif

    // A fall in the final timer cycle keeps the frame alive.
    assign timeout = (state_q != IDLE) && !fall && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        frame_err_d = 1'b0;
        good_frame  = 1'b0;
        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE:   if (!ddata) state_d = DATA;
                DATA:   if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (ddata && parity_ok) good_frame  = 1'b1;
                    else                    frame_err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            sreg_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE || fall || timeout) timer_q <= '0;
            else                                    timer_q <= timer_q + 1'b1;
            if (fall && state_q == IDLE) begin
                bit_cnt_q <= '0;
            end else if (fall && state_q == DATA) begin
                sreg_q    <= {ddata, sreg_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // Holding register: a new byte may replace the held one only in its accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
            overrun   <= good_frame && data_valid && !data_ready;
            if (good_frame && (!data_valid || data_ready)) begin
                data_out   <= sreg_q;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed PS/2 frames plus random bytes against a frame-level model.
module tb_ps2_rx_ctrl;

    localparam int DEB     = 16;
    localparam int TMO     = 2000;
    localparam int HALF    = 200;
    localparam int LAT     = 1 + 2 + DEB;   // raw stop fall -> data_valid / frame_err seen
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN  = 1'b1;
`else
    localparam bit PAR_EN  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    ps2_rx_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor on the falling edge: pulse counts, timestamps, pulse-shape violations.
    int   err_cnt = 0, ovr_cnt = 0, err_cyc = 0, rise_cyc = 0, pulse_viol = 0;
    logic err_prev = 1'b0, ovr_prev = 1'b0, valid_prev = 1'b0, busy_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) begin err_cnt++; err_cyc = cyc; end
            if (overrun) ovr_cnt++;
            if ((frame_err && err_prev) || (overrun && ovr_prev) || (frame_err && overrun)) pulse_viol++;
            if (data_valid && !valid_prev) rise_cyc = cyc;
            if (busy) busy_seen = 1'b1;
        end
        err_prev   = frame_err;
        ovr_prev   = overrun;
        valid_prev = data_valid;
    end

    // Reference model: the byte holding register as seen by the consumer.
    logic       valid_m = 1'b0;
    logic [7:0] data_m  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first n bits of an 11-bit frame (bit 0 first); returns cycle of the last raw fall.
    task automatic send_raw(input logic [10:0] bits, input int n, output int last_fall);
        last_fall = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            wait_clk(HALF);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        logic par;
        par = ~(^d) ^ par_flip;
        return {stop, par, d, 1'b0};
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par_flip, input logic stop);
        int  e0, o0, stop_cyc;
        logic good, exp_ovr;
        e0 = err_cnt;
        o0 = ovr_cnt;
        send_raw(make_frame(d, par_flip, stop), 11, stop_cyc);
        wait_clk(50);
        good    = stop && !(PAR_EN && par_flip);
        exp_ovr = good && valid_m;
        if (good && !valid_m) begin
            valid_m = 1'b1;
            data_m  = d;
            check({tag, "_latency"}, rise_cyc - stop_cyc, LAT);
        end
        if (!good) check({tag, "_err_time"}, err_cyc - stop_cyc, LAT);
        check({tag, "_valid"}, data_valid, valid_m);
        check({tag, "_data"}, data_out, data_m);
        check({tag, "_err"}, err_cnt - e0, good ? 0 : 1);
        check({tag, "_ovr"}, ovr_cnt - o0, exp_ovr ? 1 : 0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic accept();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        valid_m    = 1'b0;
        check("accept_valid_drop", data_valid, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, data_out, 8'h00);
        check({tag, "_valid"}, data_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ferr"}, frame_err, 1'b0);
        check({tag, "_ovr"}, overrun, 1'b0);
    endtask

    initial begin
        int last_fall, e0, w;
        logic [7:0] rb;
        logic       rflip, rstop;

        wait_clk(5);
        check_idle_outputs("in_reset");
        rst = 1'b0;
        wait_clk(40);
        check_idle_outputs("after_reset");

        run_frame("f1c", 8'h1C, 1'b0, 1'b1);
        accept();

        run_frame("ff0", 8'hF0, 1'b0, 1'b1);
        run_frame("f1c_ovr", 8'h1C, 1'b0, 1'b1);
        accept();

        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(1, DEB - 1);
            @(negedge clk);
            ps2_clk = 1'b0;
            wait_clk(w);
            ps2_clk = 1'b1;
            wait_clk(60);
        end
        check("glitch_busy", busy_seen, 1'b0);
        check("glitch_valid", data_valid, 1'b0);

        run_frame("f55_badstop", 8'h55, 1'b0, 1'b0);

        e0 = err_cnt;
        send_raw(make_frame(8'h3A, 1'b0, 1'b1), 4, last_fall);
        check("tmo_busy_before", busy, 1'b1);
        wait_clk(TMO + 100);
        check("tmo_err_count", err_cnt - e0, 1);
        check("tmo_err_time", err_cyc - last_fall, LAT + TMO);
        check("tmo_busy_after", busy, 1'b0);
        run_frame("f29", 8'h29, 1'b0, 1'b1);
        accept();

        run_frame("f1c_parity", 8'h1C, 1'b1, 1'b1);
        if (valid_m) accept();

        for (int i = 0; i < 6; i++) begin
            rb    = 8'($urandom);
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 4) != 0);
            if (valid_m && $urandom_range(0, 1) == 1) accept();
            run_frame("rand", rb, rflip, rstop);
        end

        if (!valid_m) run_frame("pre_rst", 8'h6B, 1'b0, 1'b1);
        send_raw(make_frame(8'hC3, 1'b0, 1'b1), 5, last_fall);
        check("midframe_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(3);
        check_idle_outputs("midframe_rst");
        rst     = 1'b0;
        valid_m = 1'b0;
        data_m  = 8'h00;
        wait_clk(40);
        check_idle_outputs("post_rst");
        run_frame("fa5_clean", 8'hA5, 1'b0, 1'b1);

        check("pulse_shape", pulse_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
